stopwatch_display: RTL
======================

Name: stopwatch_display

Overview:
- Consumer end of the clock-divider outputs: takes the sec, display and blink tick levels and turns them into a running MM:SS stopwatch on a 4-digit multiplexed 7-segment display.
- Sits between the clock divider and the board pins.
- Re-synchronises each divider output onto the master clock and edge-detects it.
- Runs a run/pause/clear state machine, a BCD time counter and a digit-scan driver.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on each divider/button input before edge detection (min 2).
- MAX_MIN, 59, highest minute value before wrap (BCD, 0..99).

Ports:
- clk  input  1  master clock (same clock that feeds the divider).
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- sec_clk  input  1  1 Hz level from divider; each rising edge = one second.
- display_clk  input  1  scan-rate level from divider; each rising edge advances the digit scan.
- blink_clk  input  1  blink-rate level from divider; used only with the optional feature.
- run_tgl  input  1  run/pause button level, already debounced; acts on rising edge.
- clear  input  1  clear button level, already debounced; acts on rising edge.
- seg  output  7  active-low cathodes, seg[0]=a … seg[6]=g.
- an  output  4  active-low digit enables, one-hot; an[0] = rightmost digit.
- dp  output  1  active-low decimal point.
- running  output  1  high while in RUN.

Behaviour:
- Input path:
  - Each of sec_clk, display_clk, blink_clk, run_tgl and clear passes through SYNC_STAGES flops, then one edge-detect flop.
  - A rising edge yields a 1-clk tick exactly SYNC_STAGES+1 clks after the input rises.
  - Falling edges produce nothing. Levels held high produce one tick only.
- FSM states: IDLE (reset state), RUN, PAUSE.
  - IDLE + run_tgl tick -> RUN.
  - RUN + run_tgl tick -> PAUSE.
  - PAUSE + run_tgl tick -> RUN.
  - clear tick in any state -> IDLE and time forced to 00:00.
  - clear has priority over run_tgl and sec ticks in the same clk.
- running = 1 exactly in RUN, registered; it updates the clk after the tick.
- Time counter:
  - Four BCD digits: m_t, m_o, s_t, s_o.
  - Increments by one second on a sec tick only while in RUN, including the clk in which the FSM is in RUN and run_tgl toggles it to PAUSE.
  - A sec tick arriving in the same clk as IDLE->RUN is NOT counted.
  - Seconds wrap: s_o 9 -> 0 carries into s_t; s_t 5 with s_o 9 -> 00 and carries into minutes.
  - Minutes count BCD up to MAX_MIN. At MAX_MIN:59 the next second gives 00:00 and the counter keeps running.
  - No binary-to-BCD arithmetic; digits never hold values above 9.
- Scan:
  - 2-bit index advances 0->1->2->3->0 on each display tick, in every state.
  - Index 0 shows s_o on an=4'b1110; index 1 shows s_t on 4'b1101; index 2 shows m_o on 4'b1011; index 3 shows m_t on 4'b0111.
  - dp=0 only at index 2 (the MM.SS separator), otherwise 1.
  - seg/an/dp are registered from index and digit values: 1 clk latency after the index or digit changes, no glitches.
- Segment codes (gfedcba, active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Reset (rst=0):
  - Immediately forces state IDLE, time 00:00, index 0, all sync/edge flops 0.
  - Outputs: seg=1000000, an=1110, dp=1, running=0.
- Reset released mid-operation: a divider input that is already high is seen as a rising edge one time; this is acceptable and documented.

Optional Feature:
- Macro: STOPWATCH_BLINK_PAUSED_EN.
- Defined: while in PAUSE and the synchronised blink_clk level is 0, an is forced to 4'b1111 and dp=1, so the display flashes at the blink rate. IDLE and RUN are unaffected.
- Not defined: blink_clk is ignored (its sync flops may be optimised away), and PAUSE displays steadily.

Test Plan:
- Release rst, no inputs -> seg=1000000, an=1110, dp=1, running=0; 4 display edges cycle an 1110->1101->1011->0111->1110.
- run_tgl edge, then 75 sec edges -> running=1, digits 01:15 (m_o=1, s_t=1, s_o=5); at index 1, seg=1111001.
- RUN, run_tgl edge, then 10 sec edges -> running=0, time unchanged; another run_tgl edge and 1 sec edge -> time advances by exactly 1.
- Preload via 59*60+59 sec edges in RUN, then 1 more -> 00:00 and running stays 1.
- clear and run_tgl rising in the same clk while in RUN at 00:42 -> IDLE, 00:00, running=0.
- With STOPWATCH_BLINK_PAUSED_EN, in PAUSE toggle blink_clk -> an=1111 while blink low, normal scan while blink high; without the macro, an keeps scanning.

Source files
------------

// File: rtl/stopwatch_display.sv
// MM:SS stopwatch on a 4-digit multiplexed 7-segment display, fed by clock-divider tick levels.
// Optional: define STOPWATCH_BLINK_PAUSED_EN to flash the display at the blink rate while paused.
module stopwatch_display #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MAX_MIN     = 59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_clk,
  input  logic       display_clk,
  input  logic       blink_clk,
  input  logic       run_tgl,
  input  logic       clear,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       running
);

  localparam logic [3:0] MAX_MT = 4'(MAX_MIN / 10);
  localparam logic [3:0] MAX_MO = 4'(MAX_MIN % 10);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_e;

  state_e      state_q, state_d;
  logic [4:0]  sync_q [SYNC_STAGES];
  logic [4:0]  sync_lvl;
  logic [3:0]  edge_q;
  logic        sec_tick, disp_tick, run_tick, clr_tick, count_en;
  logic [3:0]  so_q, so_d, st_q, st_d, mo_q, mo_d, mt_q, mt_d;
  logic [1:0]  idx_q, idx_d;
  logic        running_q;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic        dp_q, dp_d;
  logic [3:0]  digit;

  // Bit 4 (blink) is only ever used as a level, so it gets no edge flop.
  assign sync_lvl = sync_q[SYNC_STAGES-1];
  assign {clr_tick, run_tick, disp_tick, sec_tick} = sync_lvl[3:0] & ~edge_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= {blink_clk, clear, run_tgl, display_clk, sec_clk};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      edge_q <= sync_lvl[3:0];
    end
  end

  always_comb begin
    state_d = state_q;
    if (clr_tick) begin
      state_d = IDLE;
    end else if (run_tick) begin
      case (state_q)
        IDLE:    state_d = RUN;
        RUN:     state_d = PAUSE;
        PAUSE:   state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  // Counting follows the current state, so the IDLE->RUN clk never counts and RUN->PAUSE does.
  assign count_en = sec_tick && !clr_tick && (state_q == RUN);

  always_comb begin
    so_d = so_q;
    st_d = st_q;
    mo_d = mo_q;
    mt_d = mt_q;
    if (clr_tick) begin
      {mt_d, mo_d, st_d, so_d} = '0;
    end else if (count_en) begin
      if (so_q != 4'd9) begin
        so_d = so_q + 4'd1;
      end else begin
        so_d = '0;
        if (st_q != 4'd5) begin
          st_d = st_q + 4'd1;
        end else begin
          st_d = '0;
          if (mt_q == MAX_MT && mo_q == MAX_MO) begin
            mt_d = '0;
            mo_d = '0;
          end else if (mo_q != 4'd9) begin
            mo_d = mo_q + 4'd1;
          end else begin
            mo_d = '0;
            mt_d = mt_q + 4'd1;
          end
        end
      end
    end
  end

  assign idx_d = disp_tick ? idx_q + 2'd1 : idx_q;

  always_comb begin
    case (idx_q)
      2'd0:    digit = so_q;
      2'd1:    digit = st_q;
      2'd2:    digit = mo_q;
      default: digit = mt_q;
    endcase
    case (digit)
      4'd0:    seg_d = 7'b1000000;
      4'd1:    seg_d = 7'b1111001;
      4'd2:    seg_d = 7'b0100100;
      4'd3:    seg_d = 7'b0110000;
      4'd4:    seg_d = 7'b0011001;
      4'd5:    seg_d = 7'b0010010;
      4'd6:    seg_d = 7'b0000010;
      4'd7:    seg_d = 7'b1111000;
      4'd8:    seg_d = 7'b0000000;
      4'd9:    seg_d = 7'b0010000;
      default: seg_d = 7'b1111111;
    endcase
    an_d = ~(4'b0001 << idx_q);
    dp_d = (idx_q != 2'd2);
`ifdef STOPWATCH_BLINK_PAUSED_EN
    if (state_q == PAUSE && !sync_lvl[4]) begin
      an_d = '1;
      dp_d = 1'b1;
    end
`endif
  end

`ifndef STOPWATCH_BLINK_PAUSED_EN
  logic blink_unused;
  assign blink_unused = sync_lvl[4];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      {mt_q, mo_q, st_q, so_q} <= '0;
      idx_q     <= '0;
      seg_q     <= 7'b1000000;
      an_q      <= 4'b1110;
      dp_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      so_q      <= so_d;
      st_q      <= st_d;
      mo_q      <= mo_d;
      mt_q      <= mt_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      dp_q      <= dp_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign dp      = dp_q;
  assign running = running_q;

endmodule
